lsu_mem_ctrl: RTL and testbench
===============================

Name: lsu_mem_ctrl

Overview:
- Multi-cycle load/store initiator between the core's memory stage and the word-only data memory (MemRead/MemWrite, 9-bit byte address, 32-bit word, combinational read, write on posedge).
- Supports LB/LH/LW/LBU/LHU/SB/SH/SW.
- Sub-word stores use read-modify-write, because the memory has no byte enables.
- Stalls the core through req_ready until each access completes.

Parameters:
- ADDR_W, 9, byte-address width. Word index is addr[ADDR_W-1:2].
- XLEN, 32, data width. Fixed at 32; other values are unsupported.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  core presents an access this cycle
- req_ready  out  1  controller idle; request accepted when req_valid&&req_ready
- req_store  in  1  1=store, 0=load
- req_funct3  in  3  RISC-V funct3 for size/sign
- req_addr  in  ADDR_W  byte address
- req_wdata  in  XLEN  store data; low bits used for SB/SH
- resp_valid  out  1  one-cycle pulse: access finished
- resp_err  out  1  qualified by resp_valid: misaligned address or illegal funct3
- resp_rdata  out  XLEN  load result, sign/zero-extended; held until next resp
- MemRead  out  1  to data memory
- MemWrite  out  1  to data memory
- mem_addr  out  ADDR_W  to data memory; low 2 bits driven 0
- mem_wdata  out  XLEN  to data memory
- mem_rdata  in  XLEN  from data memory; combinational, valid while MemRead=1

Behaviour:
- States: IDLE, RD, WR, RESP.
- Reset values: state=IDLE; req_ready=1; resp_valid=0; resp_err=0; resp_rdata=0; MemRead=0; MemWrite=0; mem_addr=0; mem_wdata=0.
- Reset mid-operation: next cycle is IDLE and no MemWrite is issued. A pending RMW is abandoned and memory is left untouched.
- req_ready=1 only in IDLE. On accept, register store, funct3, addr and wdata. Requests while busy are ignored.
- Legality:
  - Loads: funct3 in {000,001,010,100,101}.
  - Stores: funct3 in {000,001,010}.
  - Alignment: half needs addr[0]=0; word needs addr[1:0]=0.
  - Illegal or misaligned goes IDLE->RESP with resp_err=1. No memory strobe is issued and resp_rdata is unchanged.
- Load: IDLE->RD.
  - In RD, drive MemRead=1 and mem_addr={addr[ADDR_W-1:2],2'b00}.
  - On the clock edge, register the extracted lane into resp_rdata, then go to RESP.
  - Latency: accept at edge N, resp_valid during cycle N+2.
- Lane extract:
  - Byte lane = addr[1:0], so byte k = mem_rdata[8k+7:8k].
  - Half lane = addr[1], selecting [15:0] or [31:16].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- SW: IDLE->WR. Drive MemWrite=1 with mem_wdata=req_wdata, then go to RESP. resp_valid during cycle N+2.
- SB/SH: IDLE->RD->WR->RESP.
  - In RD, register the merged word: mem_rdata with the target lane replaced by wdata[7:0] or wdata[15:0].
  - In WR, write the merged word.
  - resp_valid during cycle N+3.
- RESP: resp_valid=1 for exactly one cycle, then IDLE with req_ready=1. A back-to-back request can be accepted on the edge leaving IDLE the following cycle.
- MemRead and MemWrite are never both 1. Strobes are only asserted in RD and WR.
- Stores return resp_rdata unchanged and resp_err=0.
- Address wrap: none. The word index is the truncated address and the memory wraps naturally at 128 words.

Decomposition:
- Shared package lsu_pkg:
  - funct3 constants F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101.
  - State enum IDLE/RD/WR/RESP.
  - Function is_legal(store, funct3, addr[1:0]).
- One combinational sub-module, lsu_lane_unit. Inputs: word, funct3, addr[1:0], wdata. Outputs: extracted load value and merged store word. It is shared by the RD-state load and RMW paths.

Test Plan:
- Preload word 0x8077_F0A5 at addr 0x010. LB at 0x010 -> resp_rdata=0xFFFF_FFA5 at N+2. LBU at 0x012 -> 0x0000_0077. LH at 0x012 -> 0xFFFF_8077. LHU -> 0x0000_8077.
- SW 0xDEAD_BEEF at 0x020 -> one MemWrite cycle at N+1 with mem_addr=0x020, resp at N+2. LW 0x020 -> 0xDEAD_BEEF.
- Memory 0x1122_3344 at 0x030. SB 0x...AB at 0x031 -> RD at N+1, WR at N+2 with mem_wdata=0x1122_AB44, resp at N+3. SH 0xCAFE at 0x032 -> 0xCAFE_AB44.
- LW at 0x005, SH at 0x003, LB with funct3=3'b011 -> resp_valid with resp_err=1 at N+1. MemRead and MemWrite stay 0 throughout.
- Assert rst in the RD cycle of an SB -> next cycle IDLE, req_ready=1, MemWrite never asserted, memory word unchanged.
- Hold req_valid high continuously with alternating SW/LW -> each accepted only when req_ready=1, no request lost or duplicated, strobes mutually exclusive (assertion).

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, controller
// states and the access legality rule.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } lsu_state_e;

    // Legal = known size/sign code for the direction and naturally aligned.
    // Unsigned variants exist only for loads.
    function automatic logic is_legal(input logic       store,
                                      input logic [2:0] funct3,
                                      input logic [1:0] addr_lo);
        logic ok;
        case (funct3)
            F3_B:    ok = 1'b1;
            F3_BU:   ok = !store;
            F3_H:    ok = !addr_lo[0];
            F3_HU:   ok = !store && !addr_lo[0];
            F3_W:    ok = (addr_lo == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Core-side request/response bus plus the word-only data memory port.
// slave = controller view, master = core + memory environment view.
interface lsu_mem_ctrl_if #(
    parameter int ADDR_W = 9,
    parameter int XLEN   = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_store;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic              resp_valid;
    logic              resp_err;
    logic [XLEN-1:0]   resp_rdata;
    logic              MemRead;
    logic              MemWrite;
    logic [ADDR_W-1:0] mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic [XLEN-1:0]   mem_rdata;

    modport slave (
        input  req_valid, req_store, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_err, resp_rdata,
               MemRead, MemWrite, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_store, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_err, resp_rdata,
               MemRead, MemWrite, mem_addr, mem_wdata
    );
endinterface

// File: rtl/lsu_lane_unit.sv
// Byte/half lane logic shared by the load path and the sub-word RMW path:
// extracts + extends a lane from a memory word, and builds the merged word.
module lsu_lane_unit
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_word,
    input  logic [2:0]      i_funct3,
    input  logic [1:0]      i_addr_lo,
    input  logic [XLEN-1:0] i_wdata,
    output logic [XLEN-1:0] o_load,
    output logic [XLEN-1:0] o_merged
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_word[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_word[{i_addr_lo[1], 4'b0000} +: 16];

    // Load lane select with sign or zero extension.
    always_comb begin
        o_load = i_word;
        case (i_funct3)
            F3_B:    o_load = {{(XLEN-8){w_byte[7]}}, w_byte};
            F3_BU:   o_load = {{(XLEN-8){1'b0}}, w_byte};
            F3_H:    o_load = {{(XLEN-16){w_half[15]}}, w_half};
            F3_HU:   o_load = {{(XLEN-16){1'b0}}, w_half};
            default: o_load = i_word;
        endcase
    end

    // Replace the target lane of the old word with the store data.
    always_comb begin
        o_merged = i_word;
        case (i_funct3)
            F3_B:    o_merged[{i_addr_lo, 3'b000} +: 8]     = i_wdata[7:0];
            F3_H:    o_merged[{i_addr_lo[1], 4'b0000} +: 16] = i_wdata[15:0];
            default: o_merged = i_wdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Multi-cycle load/store initiator. Loads: IDLE->RD->RESP. SW: IDLE->WR->RESP.
// SB/SH: IDLE->RD->WR->RESP (read-modify-write, memory has no byte enables).
// Illegal/misaligned: IDLE->RESP with error, no memory strobe.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int XLEN   = 32
) (
    input  logic          clk,
    input  logic          rst,
    lsu_mem_ctrl_if.slave bus
);

    lsu_state_e        r_state;
    logic              r_store;
    logic [2:0]        r_funct3;
    logic [1:0]        r_addr_lo;
    logic [XLEN-1:0]   r_wdata;
    logic              r_req_ready;
    logic              r_resp_valid;
    logic              r_resp_err;
    logic [XLEN-1:0]   r_resp_rdata;
    logic              r_mem_read;
    logic              r_mem_write;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [XLEN-1:0]   r_mem_wdata;
    logic [XLEN-1:0]   w_load;
    logic [XLEN-1:0]   w_merged;

    lsu_lane_unit #(.XLEN(XLEN)) u_lane (
        .i_word    (bus.mem_rdata),
        .i_funct3  (r_funct3),
        .i_addr_lo (r_addr_lo),
        .i_wdata   (r_wdata),
        .o_load    (w_load),
        .o_merged  (w_merged)
    );

    assign bus.req_ready  = r_req_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_err   = r_resp_err;
    assign bus.resp_rdata = r_resp_rdata;
    assign bus.MemRead    = r_mem_read;
    assign bus.MemWrite   = r_mem_write;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;

    // Controller FSM; every output is registered so strobes are glitch-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_store      <= 1'b0;
            r_funct3     <= 3'b000;
            r_addr_lo    <= 2'b00;
            r_wdata      <= '0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.req_valid) begin
                        r_store     <= bus.req_store;
                        r_funct3    <= bus.req_funct3;
                        r_addr_lo   <= bus.req_addr[1:0];
                        r_wdata     <= bus.req_wdata;
                        r_req_ready <= 1'b0;
                        if (!is_legal(bus.req_store, bus.req_funct3, bus.req_addr[1:0])) begin
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_state      <= RESP;
                        end else begin
                            r_mem_addr <= {bus.req_addr[ADDR_W-1:2], 2'b00};
                            if (bus.req_store && bus.req_funct3 == F3_W) begin
                                r_mem_write <= 1'b1;
                                r_mem_wdata <= bus.req_wdata;
                                r_state     <= WR;
                            end else begin
                                r_mem_read <= 1'b1;
                                r_state    <= RD;
                            end
                        end
                    end
                end
                RD: begin
                    r_mem_read <= 1'b0;
                    if (r_store) begin
                        // Sub-word store: capture the merged word for the WR cycle.
                        r_mem_wdata <= w_merged;
                        r_mem_write <= 1'b1;
                        r_state     <= WR;
                    end else begin
                        r_resp_rdata <= w_load;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b0;
                        r_state      <= RESP;
                    end
                end
                WR: begin
                    r_mem_write  <= 1'b0;
                    r_resp_valid <= 1'b1;
                    r_resp_err   <= 1'b0;
                    r_state      <= RESP;
                end
                RESP: begin
                    r_resp_valid <= 1'b0;
                    r_req_ready  <= 1'b1;
                    r_state      <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: word memory model, directed cases with literal
// expectations, and randomized traffic checked every cycle against a
// cycle-schedule reference model.
module tb_lsu_mem_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    lsu_mem_ctrl_if #(.ADDR_W(9), .XLEN(32)) bus ();

    lsu_mem_ctrl #(.ADDR_W(9), .XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- data memory (128 words, write on posedge) ------------
    logic [31:0] mem [128];
    assign bus.mem_rdata = mem[bus.mem_addr[8:2]];

    initial begin
        logic       p_we;
        logic [6:0] p_idx;
        logic [31:0] p_d;
        for (int i = 0; i < 128; i++) mem[i] = $urandom;
        forever begin
            @(negedge clk);
            p_we  = bus.MemWrite;
            p_idx = bus.mem_addr[8:2];
            p_d   = bus.mem_wdata;
            @(posedge clk);
            if (p_we) mem[p_idx] = p_d;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference rules ----------------
    function automatic int acc_size(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic bit tb_legal(input logic st, input logic [2:0] f3, input logic [8:0] a);
        int sz = acc_size(f3);
        if (sz == 0) return 0;
        if (st && f3 > 3'd2) return 0;
        return (int'(a) % sz) == 0;
    endfunction

    function automatic logic [31:0] tb_load(input logic [31:0] w, input logic [2:0] f3, input logic [8:0] a);
        int sz = acc_size(f3);
        int sh = (int'(a) % 4) * 8;
        logic [31:0] v = w >> sh;
        if (sz == 1) begin
            v = v & 32'hFF;
            if (f3 == 3'd0 && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (sz == 2) begin
            v = v & 32'hFFFF;
            if (f3 == 3'd1 && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    function automatic logic [31:0] tb_merge(input logic [31:0] w, input logic [2:0] f3,
                                             input logic [8:0] a, input logic [31:0] d);
        int sh = (int'(a) % 4) * 8;
        logic [31:0] mask = ((acc_size(f3) == 1) ? 32'hFF : 32'hFFFF) << sh;
        return (w & ~mask) | ((d << sh) & mask);
    endfunction

    // ---------------- per-cycle reference model + compare ----------------
    logic [31:0] shadow [128];
    bit          started = 0;
    int          m_busy_end = -1;
    int          m_resp_cyc = -1;
    int          m_rd_cyc = -1;
    int          m_wr_cyc = -1;
    logic        m_err = 0;
    logic [31:0] m_rdata = 0;
    logic [31:0] m_rdata_next = 0;
    logic [8:0]  m_addr = 0;
    logic [31:0] m_wr_data = 0;

    always @(negedge clk) begin
        bit ex_rdy, ex_vld, ex_rd, ex_wr;
        ex_rdy = (cyc > m_busy_end);
        ex_vld = (cyc == m_resp_cyc);
        ex_rd  = (cyc == m_rd_cyc);
        ex_wr  = (cyc == m_wr_cyc);
        if (ex_vld) m_rdata = m_rdata_next;
        if (started) begin
            chk("req_ready", 32'(bus.req_ready), 32'(ex_rdy));
            chk("resp_valid", 32'(bus.resp_valid), 32'(ex_vld));
            chk("MemRead", 32'(bus.MemRead), 32'(ex_rd));
            chk("MemWrite", 32'(bus.MemWrite), 32'(ex_wr));
            chk("strobe_excl", 32'(bus.MemRead & bus.MemWrite), 32'd0);
            chk("resp_rdata", bus.resp_rdata, m_rdata);
            if (ex_vld) chk("resp_err", 32'(bus.resp_err), 32'(m_err));
            if (ex_rd || ex_wr) chk("mem_addr", 32'(bus.mem_addr), 32'(m_addr));
            if (ex_wr) chk("mem_wdata", bus.mem_wdata, m_wr_data);
        end
        if (ex_wr) shadow[m_addr[8:2]] = m_wr_data;
        if (rst) begin
            if (!started) for (int i = 0; i < 128; i++) shadow[i] = mem[i];
            started    = 1;
            m_busy_end = cyc;
            m_resp_cyc = -1;
            m_rd_cyc   = -1;
            m_wr_cyc   = -1;
            m_rdata    = 0;
        end else if (started && ex_rdy && bus.req_valid) begin
            m_addr       = {bus.req_addr[8:2], 2'b00};
            m_rdata_next = m_rdata;
            m_err        = 0;
            if (!tb_legal(bus.req_store, bus.req_funct3, bus.req_addr)) begin
                m_err      = 1;
                m_resp_cyc = cyc + 1;
            end else if (!bus.req_store) begin
                m_rd_cyc     = cyc + 1;
                m_resp_cyc   = cyc + 2;
                m_rdata_next = tb_load(shadow[bus.req_addr[8:2]], bus.req_funct3, bus.req_addr);
            end else if (bus.req_funct3 == 3'd2) begin
                m_wr_cyc   = cyc + 1;
                m_wr_data  = bus.req_wdata;
                m_resp_cyc = cyc + 2;
            end else begin
                m_rd_cyc   = cyc + 1;
                m_wr_cyc   = cyc + 2;
                m_wr_data  = tb_merge(shadow[bus.req_addr[8:2]], bus.req_funct3,
                                      bus.req_addr, bus.req_wdata);
                m_resp_cyc = cyc + 3;
            end
            m_busy_end = m_resp_cyc;
        end
    end

    // ---------------- drivers ----------------
    task automatic issue(input logic st, input logic [2:0] f3, input logic [8:0] a,
                         input logic [31:0] wd, input bit hold);
        int n = 0;
        bus.req_valid  = 1'b1;
        bus.req_store  = st;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        @(negedge clk);
        while (!bus.req_ready) begin
            n++;
            if (n > 50) begin
                chk("accept_timeout", 32'd1, 32'd0);
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        if (!hold) bus.req_valid = 1'b0;
    endtask

    task automatic wait_resp(output logic [31:0] rd, output logic er, output int lat);
        lat = 1;
        forever begin
            @(negedge clk);
            if (bus.resp_valid) break;
            lat++;
            if (lat > 8) begin
                chk("resp_timeout", 32'd1, 32'd0);
                break;
            end
        end
        rd = bus.resp_rdata;
        er = bus.resp_err;
    endtask

    task automatic op(input logic st, input logic [2:0] f3, input logic [8:0] a,
                      input logic [31:0] wd, output logic [31:0] rd, output logic er, output int lat);
        issue(st, f3, a, wd, 0);
        wait_resp(rd, er, lat);
    endtask

    task automatic lit(input string name, input logic st, input logic [2:0] f3, input logic [8:0] a,
                       input logic [31:0] wd, input int exp_lat, input logic exp_err,
                       input logic [31:0] exp_rd);
        logic [31:0] rd;
        logic        er;
        int          lat;
        op(st, f3, a, wd, rd, er, lat);
        chk({name, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({name, "_err"}, 32'(er), 32'(exp_err));
        chk({name, "_rdata"}, rd, exp_rd);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        bus.req_valid  = 1'b0;
        bus.req_store  = 1'b0;
        bus.req_funct3 = 3'd0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
        @(posedge clk); #1;

        // loads with lane extract
        lit("sw_pre", 1, 3'd2, 9'h010, 32'h8077_F0A5, 2, 0, 32'h0);
        lit("lb",     0, 3'd0, 9'h010, 32'h0, 2, 0, 32'hFFFF_FFA5);
        lit("lbu",    0, 3'd4, 9'h012, 32'h0, 2, 0, 32'h0000_0077);
        lit("lh",     0, 3'd1, 9'h012, 32'h0, 2, 0, 32'hFFFF_8077);
        lit("lhu",    0, 3'd5, 9'h012, 32'h0, 2, 0, 32'h0000_8077);

        // SW: one write cycle right after accept
        issue(1, 3'd2, 9'h020, 32'hDEAD_BEEF, 0);
        @(negedge clk);
        chk("sw_memwrite", 32'(bus.MemWrite), 32'd1);
        chk("sw_mem_addr", 32'(bus.mem_addr), 32'h020);
        @(negedge clk);
        chk("sw_resp", 32'(bus.resp_valid), 32'd1);
        @(posedge clk); #1;
        lit("lw", 0, 3'd2, 9'h020, 32'h0, 2, 0, 32'hDEAD_BEEF);

        // sub-word RMW
        lit("sw_rmw", 1, 3'd2, 9'h030, 32'h1122_3344, 2, 0, 32'hDEAD_BEEF);
        issue(1, 3'd0, 9'h031, 32'h5555_55AB, 0);
        @(negedge clk);
        chk("sb_rd", 32'(bus.MemRead), 32'd1);
        @(negedge clk);
        chk("sb_wr", 32'(bus.MemWrite), 32'd1);
        chk("sb_wdata", bus.mem_wdata, 32'h1122_AB44);
        @(negedge clk);
        chk("sb_resp", 32'(bus.resp_valid), 32'd1);
        @(posedge clk); #1;
        lit("sh", 1, 3'd1, 9'h032, 32'h0000_CAFE, 3, 0, 32'hDEAD_BEEF);
        chk("sh_mem", mem[12], 32'hCAFE_AB44);
        lit("lw_rmw", 0, 3'd2, 9'h030, 32'h0, 2, 0, 32'hCAFE_AB44);

        // errors: immediate response, rdata unchanged
        lit("lw_mis", 0, 3'd2, 9'h005, 32'h0, 1, 1, 32'hCAFE_AB44);
        lit("sh_mis", 1, 3'd1, 9'h003, 32'h0, 1, 1, 32'hCAFE_AB44);
        lit("f3_bad", 0, 3'd3, 9'h010, 32'h0, 1, 1, 32'hCAFE_AB44);
        lit("sbu_bad", 1, 3'd4, 9'h010, 32'h0, 1, 1, 32'hCAFE_AB44);

        // reset during the RD cycle of an SB
        lit("sw_rst", 1, 3'd2, 9'h040, 32'h5566_7788, 2, 0, 32'hCAFE_AB44);
        issue(1, 3'd0, 9'h041, 32'h0000_00AB, 0);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_mid_write", 32'(bus.MemWrite), 32'd0);
        repeat (3) @(negedge clk);
        chk("rst_mid_mem", mem[16], 32'h5566_7788);
        @(posedge clk); #1;

        // req_valid held high across alternating SW/LW
        for (int i = 0; i < 12; i++) begin
            logic [8:0] a = 9'({$urandom_range(0, 15), 2'b00});
            issue(1, 3'd2, a, $urandom, 1);
            issue(0, 3'd2, a, 32'h0, i != 11);
        end
        repeat (4) @(posedge clk);
        #1;

        // randomized mix (including illegal and misaligned)
        for (int i = 0; i < 200; i++) begin
            logic [2:0] f3 = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7))
                                                        : ((i % 5 == 0) ? 3'd2 : 3'($urandom_range(0, 5)));
            op(1'($urandom_range(0, 1)), f3, 9'($urandom_range(0, 63)), $urandom, rd, er, lat);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        repeat (4) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
